// File: rtl/nx_bit_pack_seq.sv
// Packs variable-width LSB-first symbols into OUT_W-bit words; one cycle from accept to first word.
// Input is accepted only when idle; output words are registered and hold while out_ready is low.
module nx_bit_pack_seq #(
  parameter int IN_W  = 256,
  parameter int OUT_W = 64,
  localparam int IN_SZ_W  = $clog2(IN_W),
  localparam int OUT_SZ_W = $clog2(OUT_W),
  localparam int CNT_W    = $clog2(IN_W / OUT_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic [IN_SZ_W:0]      in_size,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [OUT_SZ_W:0]     out_bits,
  output logic                  out_last
);

  localparam int HW    = IN_W + OUT_W;
  localparam int TOT_W = IN_SZ_W + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]          state;
  logic [HW-1:0]       hold;
  logic [CNT_W-1:0]    wcnt;
  logic [CNT_W-1:0]    idx;
  logic                last_q;
  logic [OUT_W-1:0]    res;
  logic [OUT_SZ_W-1:0] res_cnt;

  logic [IN_SZ_W:0]    size_sat;
  logic [IN_W-1:0]     in_m;
  logic [OUT_W-1:0]    res_m;
  logic [TOT_W-1:0]    tot;
  logic [HW-1:0]       hold_n;
  logic [CNT_W-1:0]    wcnt_n;
  logic [OUT_SZ_W-1:0] res_cnt_n;
  logic [OUT_W-1:0]    res_n;
  logic [CNT_W-1:0]    idx_nxt;

  function automatic logic [OUT_W-1:0] word_at(input logic [HW-1:0] h, input logic [CNT_W-1:0] i);
    word_at = OUT_W'(h >> (int'(i) * OUT_W));
  endfunction

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state != S_IDLE);
  assign idx_nxt   = idx + CNT_W'(1);

  // Combine residual with the incoming symbol and split into whole words plus a new residual.
  always_comb begin
    size_sat  = (int'(in_size) > IN_W) ? (IN_SZ_W+1)'(IN_W) : in_size;
    in_m      = in_data & ~({IN_W{1'b1}} << size_sat);
    res_m     = res & ~({OUT_W{1'b1}} << res_cnt);
    tot       = TOT_W'(res_cnt) + TOT_W'(size_sat);
    hold_n    = HW'(res_m) | (HW'(in_m) << res_cnt);
    wcnt_n    = CNT_W'(tot / TOT_W'(OUT_W));
    res_cnt_n = OUT_SZ_W'(tot % TOT_W'(OUT_W));
    res_n     = OUT_W'(hold_n >> (int'(wcnt_n) * OUT_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hold     <= '0;
      wcnt     <= '0;
      idx      <= '0;
      last_q   <= 1'b0;
      res      <= '0;
      res_cnt  <= '0;
      out_data <= '0;
      out_bits <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            hold    <= hold_n;
            wcnt    <= wcnt_n;
            idx     <= '0;
            last_q  <= in_last;
            res     <= res_n;
            res_cnt <= res_cnt_n;
            if (wcnt_n != '0) begin
              state    <= S_DRAIN;
              out_data <= hold_n[OUT_W-1:0];
              out_bits <= (OUT_SZ_W+1)'(OUT_W);
              out_last <= in_last && (res_cnt_n == '0) && (wcnt_n == CNT_W'(1));
            end else if (in_last) begin
              state    <= S_FLUSH;
              out_data <= res_n;
              out_bits <= {1'b0, res_cnt_n};
              out_last <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx == wcnt - CNT_W'(1)) begin
              // A frame ending on a word boundary already flagged out_last on this word.
              if (last_q && (res_cnt != '0)) begin
                state    <= S_FLUSH;
                out_data <= res_m;
                out_bits <= {1'b0, res_cnt};
                out_last <= 1'b1;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              idx      <= idx_nxt;
              out_data <= word_at(hold, idx_nxt);
              out_bits <= (OUT_SZ_W+1)'(OUT_W);
              out_last <= last_q && (res_cnt == '0) && (idx_nxt == wcnt - CNT_W'(1));
            end
          end
        end
        S_FLUSH: begin
          if (out_ready) begin
            res     <= '0;
            res_cnt <= '0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
